// File: rtl/uart_pkg.sv
// Shared UART constants: bit-period/half-period clock counts for 50 MHz and
// the receiver state encoding.
package uart_pkg;

  // 50 MHz / 9600 and 50 MHz / 19200, shared with the TX-side enable generator.
  localparam logic [15:0] BIT0  = 16'h1458;  // 5208
  localparam logic [15:0] BIT1  = 16'h0A2C;  // 2604
  localparam logic [15:0] HALF0 = 16'h0A2C;  // 2604
  localparam logic [15:0] HALF1 = 16'h0516;  // 1302

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP,
    S_BREAK = ST_BREAK
  } rx_state_t;

  // Pick the count for the latched rate: 0 selects the slow rate.
  function automatic logic [15:0] rate_pick(input logic       sel_q,
                                            input logic [15:0] slow,
                                            input logic [15:0] fast);
    return sel_q ? fast : slow;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: line input and rate select in, byte/status out,
// plus the FSM state for observation.
interface uart_rx_if;
  import uart_pkg::*;

  // rxvalid is a one-cycle valid with no ready: there is no backpressure, so
  // the consumer must take rxdata in the cycle rxvalid is high. frame_err is a
  // one-cycle pulse of the same kind and is never high together with rxvalid.
  logic       sel;
  logic       rxd;
  logic [7:0] rxdata;
  logic       rxvalid;
  logic       frame_err;
  logic       busy;
  rx_state_t  state;

  modport master (
    input  sel,
    input  rxd,
    output rxdata,
    output rxvalid,
    output frame_err,
    output busy,
    output state
  );

  modport slave (
    output sel,
    output rxd,
    input  rxdata,
    input  rxvalid,
    input  frame_err,
    input  busy,
    input  state
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; resets to RESET_VAL
// (all ones by default, matching an idle-high serial line).
module sync_2ff #(
  parameter int           W         = 1,
  parameter logic [W-1:0] RESET_VAL = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit with a bit-period counter, emits
// one-cycle rxvalid / frame_err pulses and parks in BREAK while the line is low.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [15:0] P_BIT0  = BIT0,
  parameter logic [15:0] P_BIT1  = BIT1,
  parameter logic [15:0] P_HALF0 = HALF0,
  parameter logic [15:0] P_HALF1 = HALF1
) (
  input  logic      clk,
  input  logic      n_rst,
  uart_rx_if.master bus
);

  rx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shreg;
  logic        r_sel_q;
  logic [7:0]  r_rxdata;
  logic        r_rxvalid;
  logic        r_frame_err;
  logic        r_busy;

  rx_state_t   w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_bit_idx_nxt;
  logic [7:0]  w_shreg_nxt;
  logic        w_sel_q_nxt;
  logic [7:0]  w_rxdata_nxt;
  logic        w_rxvalid_nxt;
  logic        w_frame_err_nxt;
  logic        w_rxd_s;
  logic [15:0] w_bit_last;
  logic [15:0] w_half_last;

  sync_2ff #(
    .W         (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .i_d   (bus.rxd),
    .o_q   (w_rxd_s)
  );

  // Rate comes from the value latched at frame start, so a mid-frame sel
  // change only affects the next frame.
  assign w_bit_last  = rate_pick(r_sel_q, P_BIT0,  P_BIT1)  - 16'd1;
  assign w_half_last = rate_pick(r_sel_q, P_HALF0, P_HALF1) - 16'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shreg     <= 8'h00;
      r_sel_q     <= 1'b0;
      r_rxdata    <= 8'h00;
      r_rxvalid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shreg     <= w_shreg_nxt;
      r_sel_q     <= w_sel_q_nxt;
      r_rxdata    <= w_rxdata_nxt;
      r_rxvalid   <= w_rxvalid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shreg_nxt     = r_shreg;
    w_sel_q_nxt     = r_sel_q;
    w_rxdata_nxt    = r_rxdata;
    w_rxvalid_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = 16'd0;
          w_sel_q_nxt = bus.sel;
        end
      end

      S_START: begin
        if (r_cnt == w_half_last) begin
          w_cnt_nxt = 16'd0;
          // A line that is high again at the start-bit centre was a glitch.
          if (!w_rxd_s) begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_DATA: begin
        if (r_cnt == w_bit_last) begin
          w_cnt_nxt   = 16'd0;
          w_shreg_nxt = {w_rxd_s, r_shreg[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      S_STOP: begin
        if (r_cnt == w_bit_last) begin
          w_cnt_nxt = 16'd0;
          if (w_rxd_s) begin
            w_rxdata_nxt  = r_shreg;
            w_rxvalid_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end

      // Wait out a held-low line instead of decoding it as repeated 0x00.
      S_BREAK: begin
        if (w_rxd_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 16'd0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  assign bus.rxdata    = r_rxdata;
  assign bus.rxvalid   = r_rxvalid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;
  assign bus.state     = r_state;

endmodule
